// File: rtl/pingpong_frame_ctrl.sv
// rtl/pingpong_frame_ctrl.sv - ping-pong 1bpp frame-buffer controller between pixel writer and VGA reader
//
// Purpose:
//   Owns two 1-bit-per-pixel RAM banks. The writer fills the bank not being
//   displayed; banks swap only at a VGA frame end, and only once a complete
//   frame is waiting. Malformed frames are discarded and frames arriving while
//   a finished frame is still waiting are dropped and counted.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   wr_vld/wr_din/wr_sop/wr_eop  writer pixel stream (sop/eop qualified by wr_vld)
//   rd_addr/rd_en/rd_end       VGA read address, read enable, frame-end pulse
//   rd_dout                    displayed pixel, RAM_LAT cycles after rd_en
//   ram_waddr/ram_wdata        shared bank write address/data (registered)
//   ram0_wen/ram1_wen          per-bank write enables (registered)
//   ram_raddr                  shared bank read address (combinational)
//   ram0_ren/ram1_ren          per-bank read enables (combinational)
//   ram0_q/ram1_q              bank read data
//   rd_sel                     displayed bank; the write bank is ~rd_sel
//   disp_valid                 displayed bank holds a complete frame
//   wr_end                     pulse with the final pixel write of a frame
//   frm_err                    pulse when a malformed frame is discarded/restarted
//   drop_cnt                   saturating count of frames dropped while FULL

`timescale 1ns/1ps

module pingpong_frame_ctrl #(
  parameter int FRAME_PIXELS = 64000,
  parameter int ADDR_W       = 16,
  parameter int RAM_LAT      = 1,
  parameter int DROP_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_vld,
  input  logic              wr_din,
  input  logic              wr_sop,
  input  logic              wr_eop,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_en,
  input  logic              rd_end,
  output logic              rd_dout,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic              ram_wdata,
  output logic              ram0_wen,
  output logic              ram1_wen,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              ram0_ren,
  output logic              ram1_ren,
  input  logic              ram0_q,
  input  logic              ram1_q,
  output logic              rd_sel,
  output logic              disp_valid,
  output logic              wr_end,
  output logic              frm_err,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [1:0] S_WAIT_SOP = 2'd0;
  localparam logic [1:0] S_WRITE    = 2'd1;
  localparam logic [1:0] S_FULL     = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_PIXELS - 1);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_rd_sel;
  logic              r_disp_valid;
  logic [ADDR_W-1:0] r_waddr;
  logic              r_wdata;
  logic              r_wen0;
  logic              r_wen1;
  logic              r_wr_end;
  logic              r_frm_err;
  logic [DROP_W-1:0] r_drop_cnt;
  logic [RAM_LAT-1:0] r_sel_pipe;
  logic [RAM_LAT-1:0] r_dv_pipe;

  logic              w_in_wait;
  logic              w_in_write;
  logic              w_in_full;
  logic              w_take;
  logic [ADDR_W-1:0] w_idx;
  logic              w_last;
  logic              w_bad;
  logic              w_restart;
  logic              w_swap;
  logic              w_drop;

  assign w_in_wait  = (r_state == S_WAIT_SOP);
  assign w_in_write = (r_state == S_WRITE);
  assign w_in_full  = (r_state == S_FULL);

  // A pixel is consumed in WAIT_SOP only when it opens a frame; in WRITE every
  // valid pixel is consumed. A sop always re-anchors the pixel at index 0.
  assign w_take    = wr_vld & ((w_in_wait & wr_sop) | w_in_write);
  assign w_idx     = wr_sop ? '0 : r_cnt;
  assign w_last    = (w_idx == LAST_IDX);
  // eop must coincide exactly with the last index; either mismatch discards.
  assign w_bad     = wr_eop ^ w_last;
  assign w_restart = w_in_write & wr_sop & (r_cnt != '0);
  assign w_swap    = w_in_full & rd_end;
  assign w_drop    = w_in_full & wr_vld & wr_sop & ~(&r_drop_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_WAIT_SOP;
      r_cnt        <= '0;
      r_rd_sel     <= 1'b0;
      r_disp_valid <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= 1'b0;
      r_wen0       <= 1'b0;
      r_wen1       <= 1'b0;
      r_wr_end     <= 1'b0;
      r_frm_err    <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_wen0    <= 1'b0;
      r_wen1    <= 1'b0;
      r_wr_end  <= 1'b0;
      r_frm_err <= w_take & (w_bad | w_restart);

      if (w_drop) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end

      // Swap and pixel acceptance are mutually exclusive by state, so the
      // bank being written can never flip while a write is in flight.
      if (w_swap) begin
        r_rd_sel     <= ~r_rd_sel;
        r_disp_valid <= 1'b1;
        r_state      <= S_WAIT_SOP;
        r_cnt        <= '0;
      end else if (w_take) begin
        if (w_bad) begin
          r_state <= S_WAIT_SOP;
          r_cnt   <= '0;
        end else begin
          r_waddr  <= w_idx;
          r_wdata  <= wr_din;
          r_wen0   <= r_rd_sel;
          r_wen1   <= ~r_rd_sel;
          r_wr_end <= w_last;
          if (w_last) begin
            r_state <= S_FULL;
            r_cnt   <= '0;
          end else begin
            r_state <= S_WRITE;
            r_cnt   <= w_idx + 1'b1;
          end
        end
      end
    end
  end

  // Bank select and display-valid follow the read data through the RAM
  // latency so the output mux matches the bank that was actually read.
  generate
    if (RAM_LAT == 1) begin : g_lat1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sel_pipe <= '0;
          r_dv_pipe  <= '0;
        end else begin
          r_sel_pipe <= r_rd_sel;
          r_dv_pipe  <= r_disp_valid;
        end
      end
    end else begin : g_latn
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sel_pipe <= '0;
          r_dv_pipe  <= '0;
        end else begin
          r_sel_pipe <= {r_sel_pipe[RAM_LAT-2:0], r_rd_sel};
          r_dv_pipe  <= {r_dv_pipe[RAM_LAT-2:0], r_disp_valid};
        end
      end
    end
  endgenerate

  assign ram_raddr  = rd_addr;
  assign ram0_ren   = rd_en & ~r_rd_sel;
  assign ram1_ren   = rd_en & r_rd_sel;
  assign rd_dout    = r_dv_pipe[RAM_LAT-1] ? (r_sel_pipe[RAM_LAT-1] ? ram1_q : ram0_q) : 1'b0;

  assign ram_waddr  = r_waddr;
  assign ram_wdata  = r_wdata;
  assign ram0_wen   = r_wen0;
  assign ram1_wen   = r_wen1;
  assign rd_sel     = r_rd_sel;
  assign disp_valid = r_disp_valid;
  assign wr_end     = r_wr_end;
  assign frm_err    = r_frm_err;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_pingpong_frame_ctrl.sv
// tb/tb_pingpong_frame_ctrl.sv - scoreboard bench for pingpong_frame_ctrl

`timescale 1ns/1ps

module tb_pingpong_frame_ctrl;

  localparam int FP  = 16;
  localparam int AW  = 16;
  localparam int LAT = 1;
  localparam int DW  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_vld, wr_din, wr_sop, wr_eop;
  logic [AW-1:0] rd_addr;
  logic          rd_en, rd_end;
  logic          rd_dout;
  logic [AW-1:0] ram_waddr;
  logic          ram_wdata, ram0_wen, ram1_wen;
  logic [AW-1:0] ram_raddr;
  logic          ram0_ren, ram1_ren;
  logic          ram0_q, ram1_q;
  logic          rd_sel, disp_valid, wr_end, frm_err;
  logic [DW-1:0] drop_cnt;

  always #5 clk = ~clk;

  pingpong_frame_ctrl #(
    .FRAME_PIXELS(FP), .ADDR_W(AW), .RAM_LAT(LAT), .DROP_W(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_vld(wr_vld), .wr_din(wr_din), .wr_sop(wr_sop), .wr_eop(wr_eop),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_end(rd_end), .rd_dout(rd_dout),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram0_wen(ram0_wen), .ram1_wen(ram1_wen),
    .ram_raddr(ram_raddr), .ram0_ren(ram0_ren), .ram1_ren(ram1_ren),
    .ram0_q(ram0_q), .ram1_q(ram1_q),
    .rd_sel(rd_sel), .disp_valid(disp_valid), .wr_end(wr_end),
    .frm_err(frm_err), .drop_cnt(drop_cnt)
  );

  // Two 16-entry banks with one-cycle read latency; filled with ones on reset
  // so an ungated rd_dout shows up as a wrong value.
  logic mem0 [0:15];
  logic mem1 [0:15];
  logic rd_en_d;

  always @(posedge clk) begin
    rd_en_d <= rd_en;
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        mem0[i] <= 1'b1;
        mem1[i] <= 1'b1;
      end
      ram0_q <= 1'b1;
      ram1_q <= 1'b1;
    end else begin
      if (ram0_wen) mem0[ram_waddr[3:0]] <= ram_wdata;
      if (ram1_wen) mem1[ram_waddr[3:0]] <= ram_wdata;
      if (ram0_ren) ram0_q <= mem0[ram_raddr[3:0]];
      if (ram1_ren) ram1_q <= mem1[ram_raddr[3:0]];
    end
  end

  typedef struct packed {
    logic [1:0]  wen;   // {ram1_wen, ram0_wen}
    logic [15:0] addr;
    logic        data;
    logic        last;
  } wr_t;

  wr_t  exp_wr_q[$];
  logic exp_rd_q[$];
  int   exp_err_q[$];

  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_wbank;
  logic exp_sel;
  wr_t  mon_act, mon_exp;
  logic mon_rd_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write, an error
  // pulse or read data.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram0_wen || ram1_wen) begin
        mon_act.wen  = {ram1_wen, ram0_wen};
        mon_act.addr = ram_waddr;
        mon_act.data = ram_wdata;
        mon_act.last = wr_end;
        n_checks++;
        if (exp_wr_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_write: got wen=%b addr=%0d data=%b end=%b expected no write",
                   mon_act.wen, mon_act.addr, mon_act.data, mon_act.last);
        end else begin
          mon_exp = exp_wr_q.pop_front();
          if (mon_act !== mon_exp) begin
            n_errors++;
            $display("FAIL write: got wen=%b addr=%0d data=%b end=%b expected wen=%b addr=%0d data=%b end=%b",
                     mon_act.wen, mon_act.addr, mon_act.data, mon_act.last,
                     mon_exp.wen, mon_exp.addr, mon_exp.data, mon_exp.last);
          end
        end
      end else if (wr_end) begin
        n_checks++;
        n_errors++;
        $display("FAIL wr_end_alone: got wr_end=1 expected wr_end only with a write");
      end
      if (frm_err) begin
        n_checks++;
        if (exp_err_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_frm_err: got frm_err=1 expected 0");
        end else begin
          void'(exp_err_q.pop_front());
        end
      end
      if (rd_en_d) begin
        n_checks++;
        if (exp_rd_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_read: got rd_dout=%b with no expected read", rd_dout);
        end else begin
          mon_rd_exp = exp_rd_q.pop_front();
          if (rd_dout !== mon_rd_exp) begin
            n_errors++;
            $display("FAIL rd_dout: got %b expected %b", rd_dout, mon_rd_exp);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pixel; exp_addr < 0 means no write is expected.
  task automatic px(input logic sop, input logic eop, input logic din,
                    input int exp_addr, input logic exp_last, input logic exp_err);
    wr_vld = 1'b1; wr_sop = sop; wr_eop = eop; wr_din = din;
    if (exp_addr >= 0)
      exp_wr_q.push_back({(exp_wbank ? 2'b10 : 2'b01), 16'(exp_addr), din, exp_last});
    if (exp_err) exp_err_q.push_back(1);
    tick();
    wr_vld = 1'b0; wr_sop = 1'b0; wr_eop = 1'b0; wr_din = 1'b0;
  endtask

  // Full well-formed frame; inv=0 gives 1,0,1,0...; inv=1 gives 0,1,0,1...
  task automatic full_frame(input logic inv, input logic exp_write);
    for (int i = 0; i < FP; i++) begin
      px(i == 0, i == FP - 1, (((i % 2) == 0) ? 1'b1 : 1'b0) ^ inv,
         exp_write ? i : -1, i == FP - 1, 1'b0);
    end
  endtask

  task automatic do_read(input int addr, input logic exp_val);
    rd_addr = AW'(addr);
    rd_en   = 1'b1;
    exp_rd_q.push_back(exp_val);
    #1;
    chk("ram_raddr", 32'(ram_raddr), 32'(addr));
    chk("ren_bits", {30'd0, ram1_ren, ram0_ren}, exp_sel ? 32'd2 : 32'd1);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_swap();
    rd_end = 1'b1;
    tick();
    rd_end = 1'b0;
    exp_sel   = ~exp_sel;
    exp_wbank = ~exp_wbank;
    chk("swap_rd_sel", 32'(rd_sel), 32'(exp_sel));
    chk("swap_disp_valid", 32'(disp_valid), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_sel"}, 32'(rd_sel), 32'd0);
    chk({tag, "_disp_valid"}, 32'(disp_valid), 32'd0);
    chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
    chk({tag, "_wen"}, {30'd0, ram1_wen, ram0_wen}, 32'd0);
    chk({tag, "_wr_end"}, 32'(wr_end), 32'd0);
    chk({tag, "_frm_err"}, 32'(frm_err), 32'd0);
    chk({tag, "_waddr"}, 32'(ram_waddr), 32'd0);
    chk({tag, "_wdata"}, 32'(ram_wdata), 32'd0);
  endtask

  initial begin
    wr_vld = 0; wr_din = 0; wr_sop = 0; wr_eop = 0;
    rd_addr = '0; rd_en = 0; rd_end = 0;
    exp_wbank = 1'b1;
    exp_sel   = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Nothing displayed yet: reads are gated to 0 regardless of RAM contents.
    do_read(5, 1'b0);

    // Stray pixels before any sop are ignored.
    px(1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b0);
    px(1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b0);

    // Frame A into bank1.
    full_frame(1'b0, 1'b1);
    tick(); tick();
    chk("after_A_rd_sel", 32'(rd_sel), 32'd0);
    chk("after_A_disp_valid", 32'(disp_valid), 32'd0);

    // FULL: frames are dropped and counted, saturating at 3.
    for (int f = 0; f < 3; f++) full_frame(1'b1, 1'b0);
    chk("drop_cnt_3", 32'(drop_cnt), 32'd3);
    for (int f = 0; f < 2; f++) full_frame(1'b0, 1'b0);
    chk("drop_cnt_sat", 32'(drop_cnt), 32'd3);

    do_swap();
    do_read(2, 1'b1);
    do_read(3, 1'b0);
    do_read(15, 1'b0);

    // Early eop at pixel 9 into bank0: pixel 9 not written, error pulse.
    for (int i = 0; i < 10; i++)
      px(i == 0, i == 9, ((i % 2) == 1), (i < 9) ? i : -1, 1'b0, i == 9);
    px(1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b0);

    // Restart by sop at pixel 5, then complete the frame with rd_end
    // coinciding with the final pixel.
    for (int i = 0; i < 5; i++)
      px(i == 0, 1'b0, 1'b1, i, 1'b0, 1'b0);
    px(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    for (int i = 1; i < FP; i++) begin
      if (i == FP - 1) rd_end = 1'b1;
      px(1'b0, i == FP - 1, ((i % 2) == 1), i, i == FP - 1, 1'b0);
      rd_end = 1'b0;
    end
    tick();
    chk("coincident_no_swap", 32'(rd_sel), 32'd1);

    do_swap();
    do_read(0, 1'b0);
    do_read(2, 1'b0);
    do_read(3, 1'b1);
    do_read(9, 1'b1);

    // Reset while pixel 7 of a bank1 frame is on the bus.
    for (int i = 0; i < 7; i++)
      px(i == 0, 1'b0, ((i % 2) == 0), i, 1'b0, 1'b0);
    #5;
    wr_vld = 1'b1; wr_din = 1'b1;
    rst_n  = 1'b0;
    #2;
    chk_reset_outputs("midreset");
    wr_vld = 1'b0; wr_din = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_sel   = 1'b0;
    exp_wbank = 1'b1;
    tick();

    px(1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b0);
    px(1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0);
    px(1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b0);
    full_frame(1'b1, 1'b1);
    repeat (3) tick();

    chk("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    chk("err_queue_drained", 32'(exp_err_q.size()), 32'd0);
    chk("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pingpong_frame_ctrl.md
Name: pingpong_frame_ctrl

Overview:
Ping-pong frame-buffer controller between the edge-detection pixel stream (writer) and the VGA driver (reader). It owns two 1-bit-per-pixel RAM banks: one is written while the other is displayed. Banks swap only at a display frame boundary, and only when a complete new frame is ready. It generates the RAM write and read controls, muxes the read data back to the VGA driver, and reports completed, erroneous and dropped frames.

Parameters:
FRAME_PIXELS, 64000, pixels per frame (320x200 show window); last pixel index is FRAME_PIXELS-1
ADDR_W, 16, RAM address width; FRAME_PIXELS <= 2**ADDR_W
RAM_LAT, 1, RAM read latency in clk cycles (>=1)
DROP_W, 8, width of the dropped-frame counter

Ports:
clk  in  1  system clock, same domain as VGA driver and RAMs
rst_n  in  1  asynchronous active-low reset
wr_vld  in  1  writer pixel valid
wr_din  in  1  writer pixel value
wr_sop  in  1  first pixel of frame, qualified by wr_vld
wr_eop  in  1  last pixel of frame, qualified by wr_vld
rd_addr  in  ADDR_W  read address from VGA driver
rd_en  in  1  read enable from VGA driver
rd_end  in  1  one-cycle pulse at VGA frame end
rd_dout  out  1  read pixel to VGA driver
ram_waddr  out  ADDR_W  shared write address to both banks
ram_wdata  out  1  shared write data
ram0_wen  out  1  bank0 write enable
ram1_wen  out  1  bank1 write enable
ram_raddr  out  ADDR_W  shared read address
ram0_ren  out  1  bank0 read enable
ram1_ren  out  1  bank1 read enable
ram0_q  in  1  bank0 read data
ram1_q  in  1  bank1 read data
rd_sel  out  1  bank currently displayed; write bank is ~rd_sel
disp_valid  out  1  high once the displayed bank holds a complete frame
wr_end  out  1  one-cycle pulse: frame fully written
frm_err  out  1  one-cycle pulse: malformed frame discarded
drop_cnt  out  DROP_W  saturating count of frames discarded while FULL

Behaviour:
- Reset (async, rst_n=0): rd_sel=0, disp_valid=0, state=WAIT_SOP, pixel counter=0.
- Reset values of the remaining outputs: wen/wdata/waddr=0, wr_end=0, frm_err=0, drop_cnt=0. All outputs are registered except rd_dout, ram_raddr and ram0_ren/ram1_ren.
- Write FSM states: WAIT_SOP, WRITE, FULL.
- WAIT_SOP:
  - Any wr_vld without wr_sop is ignored.
  - wr_vld&wr_sop: write pixel 0 and go to WRITE. If wr_eop is also set and FRAME_PIXELS==1, go directly to FULL.
- WRITE, each wr_vld pixel at index n:
  - Write registered one cycle later: ram_waddr=n, ram_wdata=wr_din, and a one-cycle pulse on the wen of the write bank (ram1_wen if rd_sel=0, else ram0_wen).
  - n==FRAME_PIXELS-1 with wr_eop=1: pixel is written, wr_end pulses in the same cycle as that write, state goes to FULL.
  - wr_eop at n<FRAME_PIXELS-1, or n==FRAME_PIXELS-1 without wr_eop: the pixel is not written, frm_err pulses, state goes to WAIT_SOP.
  - wr_sop at n>0: frm_err pulses and the pixel is treated as a fresh pixel 0 (restart); state stays WRITE.
- FULL:
  - All pixels are ignored and no wen is issued.
  - Each wr_vld&wr_sop increments drop_cnt, saturating at all-ones.
- Swap:
  - Condition: rd_end=1 while the registered state is FULL.
  - Next cycle: rd_sel toggles, disp_valid=1, state goes to WAIT_SOP.
  - A frame whose completion coincides with rd_end does not swap on that pulse; it waits for the next rd_end.
  - rd_end in WAIT_SOP or WRITE has no effect.
- Read path:
  - ram_raddr=rd_addr (combinational).
  - Read enables: ram0_ren=rd_en&~rd_sel, ram1_ren=rd_en&rd_sel.
  - rd_sel is delayed RAM_LAT cycles to sel_d.
  - rd_dout = disp_valid_d ? (sel_d ? ram1_q : ram0_q) : 0, where disp_valid_d is disp_valid delayed RAM_LAT cycles.
- The write bank never equals the read bank in any cycle, including the swap cycle.
- Counter: ADDR_W bits, never exceeds FRAME_PIXELS-1. It clears on any transition to WAIT_SOP and on restart.
- Reset mid-frame: everything returns to reset values and the partial frame is lost.

Test Plan:
- FRAME_PIXELS=16; send 16 pixels (sop on 0, eop on 15) alternating 1/0 -> ram1_wen pulses 16 times at waddr 0..15, wdata 1,0,...; wr_end pulses once with the last write; no ram0_wen.
- Then pulse rd_end -> next cycle rd_sel=1, disp_valid=1. Read addr 3 with rd_en and ram1_q=1 -> rd_dout=1 RAM_LAT cycles later; ram0_ren stays 0.
- While FULL, send 3 complete frames before rd_end -> no wen, drop_cnt=3. With DROP_W=2 and 5 frames -> drop_cnt saturates at 3.
- eop at pixel 9 -> frm_err pulse, no write for pixel 9, state WAIT_SOP. The next full frame writes from addr 0.
- eop completion and rd_end in the same cycle -> no swap, rd_sel unchanged. Next rd_end -> swap.
- Assert rst_n=0 at pixel 7 of a frame -> all outputs 0, rd_sel=0, disp_valid=0. After release, non-sop pixels are ignored until wr_sop.
